// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selector and line-level bit values.
// The receiver's parity checker uses these same constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte request/serial line bundle between a byte producer and the UART transmitter.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input  TX_OUT, busy);
  modport slave  (input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, busy);
endinterface

// File: rtl/parity_calc.sv
// Combinational parity of a data word: even -> XOR of the bits, odd -> XNOR.
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);

  assign par_o = (par_typ_i == PAR_ODD) ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: one clk per bit, start + LSB-first data + optional parity + stop.
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit on the line
// DATA   | data bit [cnt_q] on the line
// PARITY | parity bit on the line
// STOP   | stop bit on the line, back to IDLE next
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   tif
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .par_o     (par_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are registered from the next state, so the line reflects a state in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = STOP_BIT;
    busy_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (tif.Data_Valid) begin
          state_d   = START;
          data_d    = tif.P_DATA;
          par_en_d  = tif.PAR_EN;
          par_typ_d = tif.PAR_TYP;
          cnt_d     = '0;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          tx_d  = data_q[cnt_d];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
      STOP: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tif.TX_OUT = tx_q;
  assign tif.busy   = busy_q;

endmodule
